// File: rtl/adda_trig_ctrl_pkg.sv
// Shared definitions for the address/data trigger sequencer.
//   - state encoding for the sequencer FSM (also the 2-bit status output)
//   - bit positions of the fields inside the 56-bit VIO trigger config word
//   - packed view of the latched config fields (bits [51:0] of the word)
package adda_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } trig_state_e;

  localparam int ADDR_LSB    = 0;
  localparam int DATA_LSB    = 32;
  localparam int ADDR_EN_BIT = 48;
  localparam int DATA_EN_BIT = 49;
  localparam int WR_SEL_BIT  = 50;
  localparam int RD_SEL_BIT  = 51;
  localparam int ARM_BIT     = 52;

  // Number of config bits captured on arm (everything below the arm bit).
  localparam int CFG_LATCH_W = ARM_BIT;

  // Field order mirrors the config word, MSB first, so a plain cast of
  // trig_cfg[51:0] lands every field in place.
  typedef struct packed {
    logic        rd_sel;
    logic        wr_sel;
    logic        data_en;
    logic        addr_en;
    logic [15:0] mdata;
    logic [31:0] maddr;
  } trig_cfg_t;

endpackage

// File: rtl/adda_trig_ctrl_if.sv
// Bus-snoop and capture-FIFO signal bundle.
//   master: bus/FIFO side (drives bus cycle + fifo_full, receives captures)
//   slave : sequencer side (samples bus cycle + fifo_full, drives captures)
// Signals:
//   addr_in/data_in  bus address/data of the current cycle
//   wr_in/rd_in      one-cycle transfer strobes
//   fifo_full        capture FIFO cannot accept a write this cycle
//   cap_we           FIFO write strobe
//   cap_data         {addr, data} of the captured cycle
//   cap_is_wr        captured cycle was a write
interface adda_trig_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]    addr_in;
  logic [DW-1:0]    data_in;
  logic             wr_in;
  logic             rd_in;
  logic             fifo_full;
  logic             cap_we;
  logic [AW+DW-1:0] cap_data;
  logic             cap_is_wr;

  modport master (
    output addr_in, data_in, wr_in, rd_in, fifo_full,
    input  cap_we, cap_data, cap_is_wr
  );

  modport slave (
    input  addr_in, data_in, wr_in, rd_in, fifo_full,
    output cap_we, cap_data, cap_is_wr
  );
endinterface

// File: rtl/adda_trig_ctrl_match.sv
// Trigger comparator: combinational match of the current bus cycle against
// the latched trigger config.
//   cfg_i      latched config fields
//   addr_i     bus address
//   data_lo_i  low 16 bits of bus data (only these are compared)
//   wr_i/rd_i  bus strobes
//   hit_o      cycle satisfies every enabled term
module adda_trig_match
  import adda_trig_pkg::*;
(
  input  trig_cfg_t   cfg_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] data_lo_i,
  input  logic        wr_i,
  input  logic        rd_i,
  output logic        hit_o
);
  logic ev, dir_ok, addr_ok, data_ok;

  assign ev      = wr_i | rd_i;
  // With both selects clear no direction qualifies, so nothing ever hits.
  assign dir_ok  = (wr_i & cfg_i.wr_sel) | (rd_i & cfg_i.rd_sel);
  assign addr_ok = ~cfg_i.addr_en | (addr_i == cfg_i.maddr);
  assign data_ok = ~cfg_i.data_en | (data_lo_i == cfg_i.mdata);
  assign hit_o   = ev & dir_ok & addr_ok & data_ok;
endmodule

// File: rtl/adda_trig_ctrl.sv
// Trigger/capture sequencer between the VIO trigger config and the addr/data
// capture FIFO. Arming latches the config; in ARMED the bus is watched for a
// match; the matching cycle plus pnum following bus cycles are written to
// the FIFO with one cycle of latency.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   trig_cfg    VIO config word (match addr/data, enables, selects, arm)
//   pnum        post-trigger bus-cycle count (sampled on arm)
//   bus         bus snoop inputs and capture FIFO outputs
//   state       00 IDLE, 01 ARMED, 10 POST, 11 DONE
//   trig_hit    one-cycle pulse, the cycle after the trigger match
//   overflow    sticky: a capture was dropped because the FIFO was full
//   cap_cnt     entries actually written this run (saturating)
module adda_trig_ctrl
  import adda_trig_pkg::*;
#(
  parameter int trig_width = 56,
  parameter int pnum_width = 10,
  parameter int addr_width = 32,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [trig_width-1:0] trig_cfg,
  input  logic [pnum_width-1:0] pnum,
  adda_trig_if.slave            bus,
  output logic [1:0]            state,
  output logic                  trig_hit,
  output logic                  overflow,
  output logic [pnum_width:0]   cap_cnt
);
  localparam logic [pnum_width:0] CNT_MAX = {1'b1, {pnum_width{1'b0}}};

  trig_state_e                      state_q, state_d;
  trig_cfg_t                        cfg_q;
  logic [pnum_width-1:0]            pnum_q, post_cnt_q, post_nxt;
  logic [pnum_width:0]              cap_cnt_q;
  logic                             arm_q, trig_hit_q, overflow_q;
  logic                             cap_we_q, cap_is_wr_q;
  logic [addr_width+data_width-1:0] cap_data_q;

  logic arm_lvl, arm_rise, run, ev, hit, trig_fire, cap_issue, post_last;
  logic unused_rsvd;

  assign unused_rsvd = ^trig_cfg[trig_width-1:ARM_BIT+1];

  assign arm_lvl  = trig_cfg[ARM_BIT];
  assign arm_rise = arm_lvl & ~arm_q;
  // A rising arm edge reloads config and overrides any match that cycle;
  // arm low aborts, so neither allows a capture.
  assign run      = arm_lvl & ~arm_rise;
  assign ev       = bus.wr_in | bus.rd_in;
  assign post_nxt = post_cnt_q + 1'b1;
  // Equality on the incremented count: pnum = 2^n-1 finishes without wrap.
  assign post_last = (post_nxt == pnum_q);

  adda_trig_match u_match (
    .cfg_i     (cfg_q),
    .addr_i    (bus.addr_in),
    .data_lo_i (bus.data_in[15:0]),
    .wr_i      (bus.wr_in),
    .rd_i      (bus.rd_in),
    .hit_o     (hit)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    if (arm_rise) begin
      state_d = ST_ARMED;
    end else if (!arm_lvl) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ARMED: if (hit) state_d = (pnum_q == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (ev && post_last) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // ---- FSM: outputs / capture decode ----
  always_comb begin
    trig_fire = 1'b0;
    cap_issue = 1'b0;
    if (run) begin
      case (state_q)
        ST_ARMED: begin
          trig_fire = hit;
          cap_issue = hit;
        end
        ST_POST:  cap_issue = ev;
        default:  cap_issue = 1'b0;
      endcase
    end
  end

  // ---- config latch, counters, capture registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q       <= 1'b0;
      cfg_q       <= '0;
      pnum_q      <= '0;
      post_cnt_q  <= '0;
      cap_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      trig_hit_q  <= 1'b0;
      cap_we_q    <= 1'b0;
      cap_is_wr_q <= 1'b0;
      cap_data_q  <= '0;
    end else begin
      arm_q      <= arm_lvl;
      trig_hit_q <= trig_fire;
      cap_we_q   <= cap_issue & ~bus.fifo_full;

      if (arm_rise) begin
        cfg_q      <= trig_cfg_t'(trig_cfg[CFG_LATCH_W-1:0]);
        pnum_q     <= pnum;
        post_cnt_q <= '0;
        cap_cnt_q  <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (trig_fire)
          post_cnt_q <= '0;
        else if (cap_issue)
          post_cnt_q <= post_nxt;   // advances even when the FIFO drops it
        if (cap_issue && bus.fifo_full)
          overflow_q <= 1'b1;
        if (cap_issue && !bus.fifo_full && cap_cnt_q != CNT_MAX)
          cap_cnt_q <= cap_cnt_q + 1'b1;
      end

      if (cap_issue && !bus.fifo_full) begin
        cap_data_q  <= {bus.addr_in, bus.data_in};
        cap_is_wr_q <= bus.wr_in;   // write wins when both strobes are high
      end
    end
  end

  assign state         = state_q;
  assign trig_hit      = trig_hit_q;
  assign overflow      = overflow_q;
  assign cap_cnt       = cap_cnt_q;
  assign bus.cap_we    = cap_we_q;
  assign bus.cap_data  = cap_data_q;
  assign bus.cap_is_wr = cap_is_wr_q;
endmodule

// File: tb/tb_adda_trig_ctrl.sv
module tb_adda_trig_ctrl;
  import adda_trig_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [55:0] trig_cfg;
  logic [9:0]  pnum;
  logic [1:0]  state;
  logic        trig_hit, overflow;
  logic [10:0] cap_cnt;

  always #5 clk = ~clk;

  adda_trig_if #(.AW(32), .DW(32)) bus ();

  adda_trig_ctrl #(
    .trig_width(56), .pnum_width(10), .addr_width(32), .data_width(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig_cfg (trig_cfg),
    .pnum     (pnum),
    .bus      (bus),
    .state    (state),
    .trig_hit (trig_hit),
    .overflow (overflow),
    .cap_cnt  (cap_cnt)
  );

  typedef struct packed {
    logic        is_wr;
    logic [63:0] data;
  } cap_t;

  cap_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hit_cnt = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] mk_cfg(input logic [31:0] a, input logic [15:0] d,
                                         input logic aen, input logic den,
                                         input logic wr, input logic rd);
    return {3'b000, 1'b0, rd, wr, den, aen, d, a};
  endfunction

  // Called at the negedge after each clock: scoreboard pops on every write.
  task automatic observe();
    cap_t e;
    if (trig_hit) hit_cnt++;
    if (bus.cap_we) begin
      if (exp_q.size() == 0) begin
        chk("spurious_cap", 72'(bus.cap_we), 72'd0);
      end else begin
        e = exp_q.pop_front();
        chk("cap_entry", 72'({bus.cap_is_wr, bus.cap_data}), 72'(e));
      end
    end
  endtask

  // One bus cycle driven at the negedge; exp_cap says whether it must land in the FIFO.
  task automatic step(input logic wr, input logic rd, input logic [31:0] a,
                      input logic [31:0] d, input logic full, input logic exp_cap);
    cap_t e;
    bus.wr_in     = wr;
    bus.rd_in     = rd;
    bus.addr_in   = a;
    bus.data_in   = d;
    bus.fifo_full = full;
    if (exp_cap) begin
      e.is_wr = wr;
      e.data  = {a, d};
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic arm(input logic [55:0] cfg, input logic [9:0] pn);
    trig_cfg = cfg;
    trig_cfg[ARM_BIT] = 1'b1;
    pnum    = pn;
    hit_cnt = 0;
    idle(1);
    chk("armed_state", 72'(state), 72'(ST_ARMED));
    chk("armed_cnt_clr", 72'(cap_cnt), 72'd0);
    chk("armed_ovf_clr", 72'(overflow), 72'd0);
  endtask

  task automatic disarm();
    trig_cfg[ARM_BIT] = 1'b0;
    idle(1);
    chk("disarm_idle", 72'(state), 72'(ST_IDLE));
  endtask

  initial begin
    rst_n         = 1'b0;
    trig_cfg      = '0;
    pnum          = '0;
    bus.wr_in     = 1'b0;
    bus.rd_in     = 1'b0;
    bus.addr_in   = '0;
    bus.data_in   = '0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 72'(state), 72'(ST_IDLE));
    chk("rst_cap_we", 72'(bus.cap_we), 72'd0);
    chk("rst_cap_cnt", 72'(cap_cnt), 72'd0);
    chk("rst_overflow", 72'(overflow), 72'd0);
    chk("rst_cap_data", 72'(bus.cap_data), 72'd0);
    rst_n = 1'b1;
    idle(2);

    // Address match on writes, pnum=3
    arm(mk_cfg(32'h1000, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0), 10'd3);
    step(1'b1, 1'b0, 32'h0000_0FFC, 32'h11, 1'b0, 1'b0);
    chk("t2_still_armed", 72'(state), 72'(ST_ARMED));
    step(1'b1, 1'b0, 32'h0000_1000, 32'hAA, 1'b0, 1'b1);
    chk("t2_trig_hit", 72'(trig_hit), 72'd1);
    chk("t2_post", 72'(state), 72'(ST_POST));
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'h2000 + 32'(i), 32'h100 + 32'(i), 1'b0, i < 3);
    chk("t2_done", 72'(state), 72'(ST_DONE));
    chk("t2_cap_cnt", 72'(cap_cnt), 72'd4);
    chk("t2_hit_pulses", 72'(hit_cnt), 72'd1);
    chk("t2_queue_empty", 72'(exp_q.size()), 72'd0);
    disarm();
    chk("t2_cnt_hold", 72'(cap_cnt), 72'd4);

    // pnum=0, data match on reads: straight to DONE
    arm(mk_cfg(32'h0, 16'h55AA, 1'b0, 1'b1, 1'b0, 1'b1), 10'd0);
    step(1'b0, 1'b1, 32'h40, 32'h1234_0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h44, 32'h1234_55AA, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h48, 32'h1234_55AA, 1'b0, 1'b1);
    chk("t3_done_direct", 72'(state), 72'(ST_DONE));
    step(1'b0, 1'b1, 32'h4C, 32'h1234_55AA, 1'b0, 1'b0);
    chk("t3_cap_cnt", 72'(cap_cnt), 72'd1);
    chk("t3_hit_pulses", 72'(hit_cnt), 72'd1);
    disarm();

    // fifo_full on 2nd and 3rd captures, pnum=4; pnum changed after arm
    arm(mk_cfg(32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1), 10'd4);
    pnum = 10'd1;
    step(1'b1, 1'b0, 32'h10, 32'h1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h14, 32'h2, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h18, 32'h3, 1'b1, 1'b0);
    idle(2);
    chk("t4_post", 72'(state), 72'(ST_POST));
    chk("t4_overflow", 72'(overflow), 72'd1);
    step(1'b1, 1'b1, 32'h1C, 32'h4, 1'b0, 1'b1);
    chk("t4_wr_wins", 72'(bus.cap_is_wr), 72'd1);
    step(1'b0, 1'b1, 32'h20, 32'h5, 1'b0, 1'b1);
    chk("t4_done", 72'(state), 72'(ST_DONE));
    step(1'b0, 1'b1, 32'h24, 32'h6, 1'b0, 1'b0);
    chk("t4_cap_cnt", 72'(cap_cnt), 72'd3);
    chk("t4_queue_empty", 72'(exp_q.size()), 72'd0);
    disarm();
    chk("t4_ovf_hold", 72'(overflow), 72'd1);

    // No direction selected: never triggers
    arm(mk_cfg(32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0), 10'd7);
    for (int i = 0; i < 100; i++)
      step(i[0] == 1'b0, i[0], 32'(i), 32'(i), 1'b0, 1'b0);
    chk("t5_armed", 72'(state), 72'(ST_ARMED));
    chk("t5_no_hit", 72'(hit_cnt), 72'd0);
    chk("t5_cap_cnt", 72'(cap_cnt), 72'd0);
    disarm();

    // Re-arm from DONE with a matching write on the arm edge
    arm(mk_cfg(32'h2000, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0), 10'd0);
    step(1'b1, 1'b0, 32'h2000, 32'h77, 1'b0, 1'b1);
    chk("t6_done", 72'(state), 72'(ST_DONE));
    chk("t6_cnt1", 72'(cap_cnt), 72'd1);
    disarm();
    trig_cfg[ARM_BIT] = 1'b1;
    step(1'b1, 1'b0, 32'h2000, 32'h78, 1'b0, 1'b0);
    chk("t6_rearmed", 72'(state), 72'(ST_ARMED));
    chk("t6_cnt_clr", 72'(cap_cnt), 72'd0);
    chk("t6_no_hit_on_edge", 72'(trig_hit), 72'd0);
    step(1'b1, 1'b0, 32'h2000, 32'h79, 1'b0, 1'b1);
    chk("t6_done2", 72'(state), 72'(ST_DONE));
    chk("t6_cnt2", 72'(cap_cnt), 72'd1);
    chk("t6_queue_empty", 72'(exp_q.size()), 72'd0);

    // Reset mid-POST
    disarm();
    arm(mk_cfg(32'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1), 10'd5);
    step(1'b1, 1'b0, 32'h30, 32'hA, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h34, 32'hB, 1'b0, 1'b1);
    chk("t7_post", 72'(state), 72'(ST_POST));
    chk("t7_cnt2", 72'(cap_cnt), 72'd2);
    rst_n    = 1'b0;
    trig_cfg = '0;
    #1;
    chk("t7_rst_state", 72'(state), 72'(ST_IDLE));
    chk("t7_rst_cap_we", 72'(bus.cap_we), 72'd0);
    chk("t7_rst_cnt", 72'(cap_cnt), 72'd0);
    chk("t7_rst_ovf", 72'(overflow), 72'd0);
    chk("t7_rst_hit", 72'(trig_hit), 72'd0);
    chk("t7_rst_data", 72'({bus.cap_is_wr, bus.cap_data}), 72'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 32'h38 + 32'(i), 32'hC, 1'b0, 1'b0);
    chk("t7_idle_after", 72'(state), 72'(ST_IDLE));
    chk("t7_cnt_after", 72'(cap_cnt), 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
